// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Checks a serial PRBS-7 stream (x^7 + x^6 + 1). The checker seeds its 7-bit
// register from the received data, confirms the prediction for LOCK_COUNT
// consecutive bits, then free-runs its own register while locked and reports
// every mismatched bit. LOSS_COUNT consecutive errors drop lock and reseed.
//
// Ports
//   Clock       : single clock, rising edge active
//   Reset       : asynchronous, active-low reset
//   data_in     : received serial bit
//   data_valid  : data_in is sampled only when 1
//   clr_count   : synchronous clear of error_count (wins over an increment)
//   lock        : registered, 1 exactly while in the locked state
//   bit_error   : one-cycle pulse, one cycle after a mismatched bit while locked
//   error_count : saturating count of bit errors seen while locked
//   lock_lost   : one-cycle pulse when lock is dropped through errors
// -----------------------------------------------------------------------------
module prbs_checker #(
   parameter int unsigned LOCK_COUNT = 32,
   parameter int unsigned LOSS_COUNT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             data_in,
   input  logic             data_valid,
   input  logic             clr_count,
   output logic             lock,
   output logic             bit_error,
   output logic [CNT_W-1:0] error_count,
   output logic             lock_lost
);

   typedef enum logic [1:0] {
      StSeed,
      StVerify,
      StLocked
   } state_e;

   localparam logic [7:0] LockTarget = 8'(LOCK_COUNT);
   localparam logic [3:0] LossTarget = 4'(LOSS_COUNT);

   state_e             state_q, state_d;
   logic [6:0]         lfsr_q, lfsr_d;
   logic [2:0]         seed_cnt_q, seed_cnt_d;
   logic [7:0]         match_cnt_q, match_cnt_d;
   logic [3:0]         err_run_q, err_run_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic               bit_error_q, bit_error_d;
   logic               lock_lost_q, lock_lost_d;
   logic               lock_q, lock_d;

   logic               predicted;
   logic               mismatch;
   logic [6:0]         seed_shift;
   logic [7:0]         match_inc;
   logic [3:0]         err_run_inc;
   logic               locked_err;
   logic               loss;

   assign predicted   = lfsr_q[6] ^ lfsr_q[5];
   assign mismatch    = data_in != predicted;
   assign seed_shift  = {lfsr_q[5:0], data_in};
   assign match_inc   = match_cnt_q + 8'd1;
   assign err_run_inc = err_run_q + 4'd1;

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= StSeed;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         lfsr_q      <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         err_run_q   <= '0;
         err_cnt_q   <= '0;
         bit_error_q <= 1'b0;
         lock_lost_q <= 1'b0;
         lock_q      <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         err_run_q   <= err_run_d;
         err_cnt_q   <= err_cnt_d;
         bit_error_q <= bit_error_d;
         lock_lost_q <= lock_lost_d;
         lock_q      <= lock_d;
      end
   end

   // Next-state and datapath update; nothing moves on an invalid cycle
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      err_run_d   = err_run_q;
      locked_err  = 1'b0;
      loss        = 1'b0;

      if (data_valid) begin
         unique case (state_q)
            StSeed: begin
               lfsr_d = seed_shift;
               if (seed_cnt_q == 3'd6) begin
                  seed_cnt_d  = 3'd0;
                  match_cnt_d = 8'd0;
                  // An all-zero seed would predict zeros forever; reseed instead
                  if (seed_shift != 7'd0) begin
                     state_d = StVerify;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + 3'd1;
               end
            end

            StVerify: begin
               lfsr_d = seed_shift;
               if (!mismatch) begin
                  match_cnt_d = match_inc;
                  if (match_inc == LockTarget) begin
                     state_d   = StLocked;
                     err_run_d = 4'd0;
                  end
               end else begin
                  // The offending bit is already the first bit of the new seed
                  match_cnt_d = 8'd0;
                  seed_cnt_d  = 3'd1;
                  state_d     = StSeed;
               end
            end

            StLocked: begin
               // Free-run on the prediction so a corrupted bit is not absorbed
               lfsr_d = {lfsr_q[5:0], predicted};
               if (mismatch) begin
                  locked_err = 1'b1;
                  err_run_d  = err_run_inc;
                  if (err_run_inc == LossTarget) begin
                     state_d     = StSeed;
                     seed_cnt_d  = 3'd0;
                     match_cnt_d = 8'd0;
                     err_run_d   = 4'd0;
                     loss        = 1'b1;
                  end
               end else begin
                  err_run_d = 4'd0;
               end
            end

            default: begin
               state_d    = StSeed;
               seed_cnt_d = 3'd0;
            end
         endcase
      end
   end

   // Output register next values
   always_comb begin
      lock_d      = (state_d == StLocked);
      bit_error_d = locked_err;
      lock_lost_d = loss;
      err_cnt_d   = err_cnt_q;
      if (clr_count) begin
         err_cnt_d = '0;
      end else if (locked_err && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   assign lock        = lock_q;
   assign bit_error   = bit_error_q;
   assign error_count = err_cnt_q;
   assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
//
// Drives a PRBS-7 stream into two checkers (16-bit and 4-bit error counters),
// applies a table of directed steps with hand-computed expected outputs, then
// runs a few multi-cycle sequences: saturation, asynchronous reset while
// locked, acquisition with gaps, all-zero input and a mismatch during verify.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

   logic        Clock;
   logic        Reset;
   logic        data_in;
   logic        data_valid;
   logic        clr_count;
   logic        lock, bit_error, lock_lost;
   logic [15:0] error_count;
   logic        lock_s, bit_error_s, lock_lost_s;
   logic [3:0]  error_count_s;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [6:0]  gen      = 7'h5A;

   prbs_checker #(
      .LOCK_COUNT (32),
      .LOSS_COUNT (4),
      .CNT_W      (16)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .clr_count   (clr_count),
      .lock        (lock),
      .bit_error   (bit_error),
      .error_count (error_count),
      .lock_lost   (lock_lost)
   );

   prbs_checker #(
      .LOCK_COUNT (32),
      .LOSS_COUNT (4),
      .CNT_W      (4)
   ) dut_s (
      .Clock       (Clock),
      .Reset       (Reset),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .clr_count   (clr_count),
      .lock        (lock_s),
      .bit_error   (bit_error_s),
      .error_count (error_count_s),
      .lock_lost   (lock_lost_s)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      int unsigned n;
      bit          valid;
      bit          flip;
      bit          clr;
      bit          e_lock;
      bit          e_be;
      bit          e_ll;
      int unsigned e_cnt;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clock of stimulus; the generator advances only on valid cycles
   task automatic drive(input bit valid, input bit flip, input bit clr);
      logic b;
      if (valid) begin
         b       = gen[6] ^ gen[5];
         gen     = {gen[5:0], b};
         data_in = b ^ flip;
      end else begin
         data_in = flip;
      end
      data_valid = valid;
      clr_count  = clr;
      @(posedge Clock);
      #1;
   endtask

   task automatic drive_raw(input bit valid, input bit d);
      data_in    = d;
      data_valid = valid;
      clr_count  = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset      = 1'b0;
      data_valid = 1'b0;
      clr_count  = 1'b0;
      data_in    = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit any_lock;

      //            n  v  f  c   lock be ll cnt
      vecs[0]  = '{38, 1, 0, 0,  0,  0, 0, 0};  // 7 seed + 31 matches
      vecs[1]  = '{ 1, 1, 0, 0,  1,  0, 0, 0};  // 39th valid bit locks
      vecs[2]  = '{10, 1, 0, 0,  1,  0, 0, 0};
      vecs[3]  = '{ 1, 1, 1, 0,  1,  1, 0, 1};  // single error
      vecs[4]  = '{ 1, 1, 0, 0,  1,  0, 0, 1};  // pulse lasts one cycle
      vecs[5]  = '{20, 1, 0, 0,  1,  0, 0, 1};  // predictions still in step
      vecs[6]  = '{ 3, 1, 1, 0,  1,  1, 0, 4};  // below loss threshold
      vecs[7]  = '{ 1, 1, 0, 0,  1,  0, 0, 4};  // good bit clears the run
      vecs[8]  = '{ 1, 1, 0, 1,  1,  0, 0, 0};  // clear
      vecs[9]  = '{ 3, 1, 1, 0,  1,  1, 0, 3};
      vecs[10] = '{ 1, 1, 1, 0,  0,  1, 1, 4};  // 4th error: loss
      vecs[11] = '{ 1, 1, 0, 0,  0,  0, 0, 4};  // seed bit 1 after loss
      vecs[12] = '{37, 1, 0, 0,  0,  0, 0, 4};  // 38 valid bits since loss
      vecs[13] = '{ 1, 1, 0, 0,  1,  0, 0, 4};  // relock on the 39th
      vecs[14] = '{ 5, 0, 1, 0,  1,  0, 0, 4};  // invalid cycles ignored
      vecs[15] = '{ 1, 1, 1, 1,  1,  1, 0, 0};  // clear beats increment

      // Reset state
      do_reset();
      check("rst_lock", lock, 0);
      check("rst_bit_error", bit_error, 0);
      check("rst_lock_lost", lock_lost, 0);
      check("rst_error_count", error_count, 0);
      check("rst_lock_s", lock_s, 0);
      check("rst_error_count_s", error_count_s, 0);

      // Table-driven main sequence
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            drive(vecs[i].valid, vecs[i].flip, vecs[i].clr);
         end
         check($sformatf("vec%0d_lock", i), lock, vecs[i].e_lock);
         check($sformatf("vec%0d_bit_error", i), bit_error, vecs[i].e_be);
         check($sformatf("vec%0d_lock_lost", i), lock_lost, vecs[i].e_ll);
         check($sformatf("vec%0d_error_count", i), error_count, vecs[i].e_cnt);
      end

      // Saturation: 20 isolated errors
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         drive(1'b1, 1'b0, 1'b0);
      end
      check("sat_count_16", error_count, 20);
      check("sat_count_4", error_count_s, 15);
      check("sat_lock_s", lock_s, 1);

      // Asynchronous reset mid-cycle while locked
      #3;
      Reset = 1'b0;
      #1;
      check("arst_lock", lock, 0);
      check("arst_lock_s", lock_s, 0);
      check("arst_lock_lost", lock_lost, 0);
      check("arst_bit_error", bit_error, 0);
      check("arst_error_count", error_count, 0);
      @(posedge Clock);
      #1;
      check("arst_no_lock_lost", lock_lost, 0);
      Reset = 1'b1;

      // Acquisition with gaps: each valid bit followed by an idle cycle
      for (int i = 0; i < 38; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 1'b0);
      end
      check("gap_lock_38", lock, 0);
      drive(1'b1, 1'b0, 1'b0);
      check("gap_lock_39", lock, 1);
      drive(1'b0, 1'b0, 1'b0);
      check("gap_lock_hold", lock, 1);

      // All-zero input: 98 zeros is exactly 14 seed rounds
      do_reset();
      any_lock = 1'b0;
      for (int i = 0; i < 98; i++) begin
         drive_raw(1'b1, 1'b0);
         if (lock) any_lock = 1'b1;
      end
      check("zero_never_lock", any_lock, 0);
      gen = 7'h5A;
      for (int i = 0; i < 38; i++) drive(1'b1, 1'b0, 1'b0);
      check("zero_then_prbs_38", lock, 0);
      drive(1'b1, 1'b0, 1'b0);
      check("zero_then_prbs_39", lock, 1);

      // Mismatch during verify: that bit is seed bit 1, the next prediction
      // uses it and misses again, so lock comes 46 bits after the flip
      do_reset();
      gen = 7'h5A;
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 44; i++) drive(1'b1, 1'b0, 1'b0);
      check("verify_miss_45", lock, 0);
      drive(1'b1, 1'b0, 1'b0);
      check("verify_miss_46", lock, 1);
      check("verify_miss_count", error_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
